dmem_responder: RTL and testbench

Data-memory responder at the far end of the MEM-stage memory interface. Accepts one load or store request per transaction from the pipeline (direction given by `m_rnw`, size and signedness by `load_sel_M`/`store_sel_M`), and performs byte-lane masking, sign or zero extension and alignment checking. It inserts a configurable number of wait states and holds `stall_M` until the response is ready. It is word-organised internal storage and sits between the MEM stage and the MEM/WB register.

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/dmem_lane_align.sv | 58 +++++
 rtl/dmem_responder.sv | 137 +++++++++++++
 tb/tb_dmem_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and state type for the data-memory responder.
// Load/store funct3 values plus request consistency helpers.
package dmem_pkg;

    localparam logic [2:0] LS_B    = 3'b000;
    localparam logic [2:0] LS_H    = 3'b001;
    localparam logic [2:0] LS_W    = 3'b010;
    localparam logic [2:0] LS_BU   = 3'b100;
    localparam logic [2:0] LS_HU   = 3'b101;
    localparam logic [2:0] LS_NONE = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    function automatic logic is_load(input logic [2:0] s);
        return s inside {LS_B, LS_H, LS_W, LS_BU, LS_HU};
    endfunction

    function automatic logic is_store(input logic [2:0] s);
        return s inside {LS_B, LS_H, LS_W};
    endfunction

    function automatic logic req_ok(
        input logic       rnw,
        input logic [2:0] lsel,
        input logic [2:0] ssel
    );
        if (rnw)
            return is_load(lsel) && (ssel == LS_NONE);
        return is_store(ssel) && (lsel == LS_NONE);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store enables/replication, load extraction
// and extension, and the misalignment flag.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        rnw,
    input  logic [2:0]  load_sel,
    input  logic [2:0]  store_sel,
    input  logic [1:0]  byte_off,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] ldata,
    output logic        misalign
);

    logic [2:0]  sel;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Size decode, lane enables and load extension for the access.
    always_comb begin
        sel      = rnw ? load_sel : store_sel;
        byte_v   = rword[{byte_off, 3'b000} +: 8];
        half_v   = byte_off[1] ? rword[31:16] : rword[15:0];
        be       = 4'b0000;
        wword    = 32'h0;
        ldata    = 32'h0;
        misalign = 1'b0;
        unique case (sel[1:0])
            2'b00: begin
                be    = 4'b0001 << byte_off;
                wword = {4{wdata[7:0]}};
            end
            2'b01: begin
                be       = byte_off[1] ? 4'b1100 : 4'b0011;
                wword    = {2{wdata[15:0]}};
                misalign = byte_off[0];
            end
            2'b10: begin
                be       = 4'b1111;
                wword    = wdata;
                misalign = |byte_off;
            end
            default: ;
        endcase
        unique case (sel)
            LS_B:    ldata = {{24{byte_v[7]}}, byte_v};
            LS_H:    ldata = {{16{half_v[15]}}, half_v};
            LS_W:    ldata = rword;
            LS_BU:   ldata = {24'h0, byte_v};
            LS_HU:   ldata = {16'h0, half_v};
            default: ldata = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: FSM with wait states, request
// latches, word array and registered response outputs.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        m_rnw,
    input  logic [2:0]  load_sel_M,
    input  logic [2:0]  store_sel_M,
    input  logic [31:0] addr_M,
    input  logic [31:0] wdata_M,
    output logic        req_ready,
    output logic        stall_M,
    output logic        resp_valid,
    output logic [31:0] rdata_W,
    output logic        misalign_err,
    output logic        req_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic        rnw_q;
    logic [2:0]  lsel_q, ssel_q;
    logic [31:0] addr_q, wdata_q;

    logic        consistent, accept;
    logic        cur_rnw;
    logic [2:0]  cur_lsel, cur_ssel;
    logic [31:0] cur_addr, cur_wdata;
    logic [AW-1:0] idx;
    logic [31:0] rword, wword, ldata;
    logic [3:0]  be;
    logic        misalign;
    logic        unused_addr;

    logic [31:0] mem [DEPTH_WORDS];

    assign consistent = req_ok(m_rnw, load_sel_M, store_sel_M);
    assign accept     = (state == IDLE) && req_valid && consistent;

    // In IDLE the live request is steered; afterwards the latched one.
    assign cur_rnw   = (state == IDLE) ? m_rnw       : rnw_q;
    assign cur_lsel  = (state == IDLE) ? load_sel_M  : lsel_q;
    assign cur_ssel  = (state == IDLE) ? store_sel_M : ssel_q;
    assign cur_addr  = (state == IDLE) ? addr_M      : addr_q;
    assign cur_wdata = (state == IDLE) ? wdata_M     : wdata_q;

    assign idx         = cur_addr[AW+1:2];
    assign rword       = mem[idx];
    assign unused_addr = ^cur_addr[31:AW+2];

    dmem_lane_align u_align (
        .rnw       (cur_rnw),
        .load_sel  (cur_lsel),
        .store_sel (cur_ssel),
        .byte_off  (cur_addr[1:0]),
        .wdata     (cur_wdata),
        .rword     (rword),
        .be        (be),
        .wword     (wword),
        .ldata     (ldata),
        .misalign  (misalign)
    );

    // Next-state logic and combinational handshake outputs.
    always_comb begin
        state_nx  = state;
        req_ready = (state == IDLE);
        stall_M   = accept || (state == WAIT);
        unique case (state)
            IDLE: if (accept) state_nx = (WS != 4'd0) ? WAIT : RESP;
            WAIT: if (cnt == 4'd1) state_nx = RESP;
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register, wait counter and request latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rnw_q   <= 1'b0;
            lsel_q  <= LS_NONE;
            ssel_q  <= LS_NONE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cnt     <= WS;
                rnw_q   <= m_rnw;
                lsel_q  <= load_sel_M;
                ssel_q  <= store_sel_M;
                addr_q  <= addr_M;
                wdata_q <= wdata_M;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Registered response, captured on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid   <= 1'b0;
            misalign_err <= 1'b0;
            rdata_W      <= 32'h0;
            req_err      <= 1'b0;
        end else begin
            resp_valid   <= (state_nx == RESP);
            misalign_err <= (state_nx == RESP) && misalign;
            rdata_W      <= ((state_nx == RESP) && cur_rnw && !misalign)
                            ? ldata : 32'h0;
            req_err      <= (state == IDLE) && req_valid && !consistent;
        end
    end

    // Store commit in RESP; misaligned stores never touch the array.
    always_ff @(posedge clk) begin
        if (!rst && (state == RESP) && !rnw_q && !misalign) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[idx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: instance 0 with two wait states, instance 1 with none.
// Vectors carry hand-computed responses.
module tb_dmem_responder;
    import dmem_pkg::*;

    typedef struct {
        logic        rnw;
        logic [2:0]  ls;
        logic [2:0]  ss;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        mis;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0]       rv, rnw, ready, stall, resp, mis, rerr;
    logic [1:0][2:0]  ls, ss;
    logic [1:0][31:0] addr, wdata, rdata;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u0 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .m_rnw(rnw[0]),
        .load_sel_M(ls[0]), .store_sel_M(ss[0]), .addr_M(addr[0]),
        .wdata_M(wdata[0]), .req_ready(ready[0]), .stall_M(stall[0]),
        .resp_valid(resp[0]), .rdata_W(rdata[0]),
        .misalign_err(mis[0]), .req_err(rerr[0])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u1 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .m_rnw(rnw[1]),
        .load_sel_M(ls[1]), .store_sel_M(ss[1]), .addr_M(addr[1]),
        .wdata_M(wdata[1]), .req_ready(ready[1]), .stall_M(stall[1]),
        .resp_valid(resp[1]), .rdata_W(rdata[1]),
        .misalign_err(mis[1]), .req_err(rerr[1])
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t ld(input logic [2:0] s, input logic [31:0] a,
                                input logic [31:0] e, input logic m);
        vec_t t;
        t.rnw = 1'b1; t.ls = s; t.ss = LS_NONE;
        t.addr = a; t.wdata = 32'h0; t.exp = e; t.mis = m;
        return t;
    endfunction

    function automatic vec_t st(input logic [2:0] s, input logic [31:0] a,
                                input logic [31:0] d, input logic m);
        vec_t t;
        t.rnw = 1'b0; t.ls = LS_NONE; t.ss = s;
        t.addr = a; t.wdata = d; t.exp = 32'h0; t.mis = m;
        return t;
    endfunction

    function automatic int ws(input int u);
        return (u == 0) ? 2 : 0;
    endfunction

    task automatic drive(input int u, input vec_t t);
        rv[u] = 1'b1; rnw[u] = t.rnw; ls[u] = t.ls; ss[u] = t.ss;
        addr[u] = t.addr; wdata[u] = t.wdata;
    endtask

    task automatic txn(input int u, input vec_t t, input string nm);
        bit seen = 0;
        bit stall_ok = 1;
        @(negedge clk);
        chk({nm, " idle_resp"}, {31'h0, resp[u]}, 32'h0);
        drive(u, t);
        #1;
        chk({nm, " ready"}, {31'h0, ready[u]}, 32'h1);
        chk({nm, " stall_acc"}, {31'h0, stall[u]}, 32'h1);
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (resp[u]) begin
                seen = 1;
                chk({nm, " latency"}, k, ws(u) + 1);
                chk({nm, " rdata"}, rdata[u], t.exp);
                chk({nm, " misalign"}, {31'h0, mis[u]}, {31'h0, t.mis});
                chk({nm, " stall_resp"}, {31'h0, stall[u]}, 32'h0);
            end else if (!stall[u]) begin
                stall_ok = 0;
            end
        end
        if (!seen) chk({nm, " timeout"}, 32'h0, 32'h1);
        chk({nm, " stall_wait"}, {31'h0, stall_ok}, 32'h1);
        rv[u] = 1'b0;
    endtask

    vec_t v[19];
    bit quiet;

    initial begin
        rv = '0; rnw = '0; ls = {LS_NONE, LS_NONE}; ss = {LS_NONE, LS_NONE};
        addr = '0; wdata = '0;

        v[0]  = st(LS_W,  32'h10,   32'hDEADBEEF, 0);
        v[1]  = ld(LS_W,  32'h10,   32'hDEADBEEF, 0);
        v[2]  = st(LS_B,  32'h13,   32'h12345680, 0);
        v[3]  = ld(LS_B,  32'h13,   32'hFFFFFF80, 0);
        v[4]  = ld(LS_BU, 32'h13,   32'h00000080, 0);
        v[5]  = ld(LS_W,  32'h10,   32'h80ADBEEF, 0);
        v[6]  = ld(LS_H,  32'h11,   32'h00000000, 1);
        v[7]  = st(LS_W,  32'h12,   32'h11111111, 1);
        v[8]  = ld(LS_W,  32'h10,   32'h80ADBEEF, 0);
        v[9]  = st(LS_H,  32'h12,   32'h0000F00D, 0);
        v[10] = ld(LS_H,  32'h12,   32'hFFFFF00D, 0);
        v[11] = ld(LS_HU, 32'h12,   32'h0000F00D, 0);
        v[12] = ld(LS_B,  32'h10,   32'hFFFFFFEF, 0);
        v[13] = ld(LS_BU, 32'h11,   32'h000000BE, 0);
        v[14] = ld(LS_H,  32'h10,   32'hFFFFBEEF, 0);
        v[15] = st(LS_W,  32'h1010, 32'h01020304, 0);
        v[16] = ld(LS_W,  32'h10,   32'h01020304, 0);
        v[17] = ld(LS_B,  32'h12,   32'h00000002, 0);
        v[18] = ld(LS_W,  32'h11,   32'h00000000, 1);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst ready", {31'h0, ready[0]}, 32'h1);
        chk("rst stall", {31'h0, stall[0]}, 32'h0);
        chk("rst resp", {31'h0, resp[0]}, 32'h0);
        chk("rst rdata", rdata[0], 32'h0);
        chk("rst mis", {31'h0, mis[0]}, 32'h0);
        chk("rst rerr", {31'h0, rerr[0]}, 32'h0);

        for (int i = 0; i < 19; i++)
            txn(0, v[i], $sformatf("vec%0d", i));

        @(negedge clk);
        drive(0, ld(LS_W, 32'h10, 32'h0, 0));
        ss[0] = LS_W;
        #1;
        chk("bad stall", {31'h0, stall[0]}, 32'h0);
        @(negedge clk);
        chk("bad req_err", {31'h0, rerr[0]}, 32'h1);
        chk("bad resp", {31'h0, resp[0]}, 32'h0);
        chk("bad ready", {31'h0, ready[0]}, 32'h1);
        rnw[0] = 1'b0; ls[0] = LS_NONE; ss[0] = LS_NONE;
        @(negedge clk);
        chk("none req_err", {31'h0, rerr[0]}, 32'h1);
        rv[0] = 1'b0;
        @(negedge clk);
        chk("bad req_err clr", {31'h0, rerr[0]}, 32'h0);
        quiet = 1;
        repeat (4) begin
            @(negedge clk);
            if (resp[0] || stall[0]) quiet = 0;
        end
        chk("bad quiet", {31'h0, quiet}, 32'h1);

        txn(0, st(LS_W, 32'h20, 32'hCAFEF00D, 0), "pre20");
        @(negedge clk);
        drive(0, st(LS_W, 32'h20, 32'h55555555, 0));
        @(negedge clk);
        chk("abort wait stall", {31'h0, stall[0]}, 32'h1);
        rst = 1'b1;
        rv[0] = 1'b0;
        @(negedge clk);
        chk("abort stall", {31'h0, stall[0]}, 32'h0);
        chk("abort ready", {31'h0, ready[0]}, 32'h1);
        chk("abort resp", {31'h0, resp[0]}, 32'h0);
        rst = 1'b0;
        quiet = 1;
        repeat (4) begin
            @(negedge clk);
            if (resp[0]) quiet = 0;
        end
        chk("abort quiet", {31'h0, quiet}, 32'h1);
        txn(0, ld(LS_W, 32'h20, 32'hCAFEF00D, 0), "post20");

        txn(1, st(LS_W, 32'h1000, 32'h0A0B0C0D, 0), "z_st0");
        txn(1, st(LS_W, 32'h4, 32'h11223344, 0), "z_st4");
        txn(1, ld(LS_W, 32'h0, 32'h0A0B0C0D, 0), "z_ld0");

        @(negedge clk);
        drive(1, ld(LS_W, 32'h4, 32'h0, 0));
        #1;
        chk("b2b stall0", {31'h0, stall[1]}, 32'h1);
        @(negedge clk);
        chk("b2b resp1", {31'h0, resp[1]}, 32'h1);
        chk("b2b rdata1", rdata[1], 32'h11223344);
        chk("b2b stall1", {31'h0, stall[1]}, 32'h0);
        addr[1] = 32'h1000;
        @(negedge clk);
        chk("b2b resp2", {31'h0, resp[1]}, 32'h0);
        chk("b2b stall2", {31'h0, stall[1]}, 32'h1);
        @(negedge clk);
        chk("b2b resp3", {31'h0, resp[1]}, 32'h1);
        chk("b2b rdata3", rdata[1], 32'h0A0B0C0D);
        rv[1] = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
